// File: rtl/fls_param.sv
// ---------------------------------------------------------------------------
// fls_param
//   Fibonacci-like sequence generator driven by a push button. Two seed terms
//   are loaded from the switches on the first two presses; every further press
//   produces f(n) = f(n-1) OP f(n-2) with OP selected at run time. The raw
//   button level is synchronised and edge-detected internally, so one press
//   is one step no matter how long it is held.
//
// Parameters
//   WIDTH  data width of seeds and terms
//   SAT    0 = wrap on overflow, 1 = clamp (add -> all-ones, sub -> zero)
//   CNT_W  width of the term counter
//
// Ports
//   clk       system clock
//   rst       asynchronous active-high reset
//   en        raw step button level, asynchronous to clk
//   clr       synchronous restart to seed entry (keeps the synchroniser)
//   d         seed value from the switches
//   mode      00 add, 01 sub (f(n-1)-f(n-2)), 10 xor, 11 or
//   f         current term, registered
//   ovf       sticky overflow/borrow flag
//   term_cnt  terms emitted including seeds, saturating
//   phase     00 SEED0, 01 SEED1, 10 RUN
// ---------------------------------------------------------------------------
module fls_param #(
    parameter int WIDTH = 7,
    parameter bit SAT   = 1'b0,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] f,
    output logic             ovf,
    output logic [CNT_W-1:0] term_cnt,
    output logic [1:0]       phase
);

    typedef enum logic [1:0] {
        SEED0   = 2'b00,
        SEED1   = 2'b01,
        RUN     = 2'b10,
        ILLEGAL = 2'b11
    } phase_t;

    // Synchroniser and edge detector
    logic r_s1, r_s2, r_s3;
    logic w_p;

    // Sequence state
    phase_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_a, r_b, r_f;
    logic [WIDTH-1:0] w_a_nxt, w_b_nxt, w_f_nxt;
    logic             r_ovf, w_ovf_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;

    // Arithmetic
    logic [WIDTH:0]   w_sum, w_diff;
    logic [WIDTH-1:0] w_r;
    logic             w_r_ovf;

    // r_s1 is the only flop allowed to go metastable; r_s2/r_s3 form the
    // rising-edge detector so a held button yields a single one-cycle pulse.
    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= en;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_p = r_s2 & ~r_s3;

    // One extra bit catches the carry (add) or the borrow (sub).
    assign w_sum  = {1'b0, r_b} + {1'b0, r_a};
    assign w_diff = {1'b0, r_b} - {1'b0, r_a};

    always_comb begin
        w_r     = '0;
        w_r_ovf = 1'b0;
        case (mode)
            2'b00: begin
                w_r_ovf = w_sum[WIDTH];
                w_r     = (SAT && w_sum[WIDTH]) ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
            end
            2'b01: begin
                w_r_ovf = w_diff[WIDTH];
                w_r     = (SAT && w_diff[WIDTH]) ? {WIDTH{1'b0}} : w_diff[WIDTH-1:0];
            end
            2'b10:   w_r = r_b ^ r_a;
            default: w_r = r_b | r_a;
        endcase
    end

    assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;

    // NOTE: every signal driven here gets a hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_f_nxt     = r_f;
        w_ovf_nxt   = r_ovf;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            SEED0: begin
                if (w_p) begin
                    w_a_nxt     = d;
                    w_f_nxt     = d;
                    w_cnt_nxt   = w_cnt_inc;
                    w_state_nxt = SEED1;
                end
            end
            SEED1: begin
                if (w_p) begin
                    w_b_nxt     = d;
                    w_f_nxt     = d;
                    w_cnt_nxt   = w_cnt_inc;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_p) begin
                    w_a_nxt   = r_b;
                    w_b_nxt   = w_r;
                    w_f_nxt   = w_r;
                    w_ovf_nxt = r_ovf | w_r_ovf;
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: w_state_nxt = SEED0;   // unreachable encoding recovers unconditionally
        endcase
    end

    // clr behaves like reset for the datapath but leaves the synchroniser
    // alone, and it overrides any pulse arriving at the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SEED0;
            r_a     <= '0;
            r_b     <= '0;
            r_f     <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else if (clr) begin
            r_state <= SEED0;
            r_a     <= '0;
            r_b     <= '0;
            r_f     <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_f     <= w_f_nxt;
            r_ovf   <= w_ovf_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign f        = r_f;
    assign ovf      = r_ovf;
    assign term_cnt = r_cnt;
    assign phase    = r_state;

endmodule

// File: tb/tb_fls_param.sv
// ---------------------------------------------------------------------------
// tb_fls_param
//   Directed bench for fls_param. Three instances share the same stimulus:
//   u_wrap (SAT=0), u_sat (SAT=1) and u_cnt (SAT=0, CNT_W=2, exercises
//   term counter saturation). Inputs change and outputs are sampled on the
//   falling clock edge; the DUT acts on the rising edge.
// ---------------------------------------------------------------------------
module tb_fls_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       clr;
    logic [6:0] d;
    logic [1:0] mode;

    logic [6:0] f0, f1, f2;
    logic       ovf0, ovf1, ovf2;
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;
    logic [1:0] ph0, ph1, ph2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fls_param #(.WIDTH(7), .SAT(1'b0), .CNT_W(8)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .d(d), .mode(mode),
        .f(f0), .ovf(ovf0), .term_cnt(cnt0), .phase(ph0)
    );

    fls_param #(.WIDTH(7), .SAT(1'b1), .CNT_W(8)) u_sat (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .d(d), .mode(mode),
        .f(f1), .ovf(ovf1), .term_cnt(cnt1), .phase(ph1)
    );

    fls_param #(.WIDTH(7), .SAT(1'b0), .CNT_W(2)) u_cnt (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .d(d), .mode(mode),
        .f(f2), .ovf(ovf2), .term_cnt(cnt2), .phase(ph2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One button press: en high for one sampled edge, then enough cycles for
    // the two-edge latency to complete. Ends on a falling edge.
    task automatic press(input logic [6:0] val);
        d  = val;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [6:0] fib_exp [5];
        fib_exp = '{7'd2, 7'd3, 7'd5, 7'd8, 7'd13};

        rst = 1'b1; en = 1'b0; clr = 1'b0; d = '0; mode = 2'b00;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_f",     f0,   0);
        check("rst_ovf",   ovf0, 0);
        check("rst_cnt",   cnt0, 0);
        check("rst_phase", ph0,  0);
        rst = 1'b0;
        @(negedge clk);

        // Fibonacci with add: seeds 1,1 then 5 steps
        mode = 2'b00;
        press(7'd1);
        check("fib_seed0_f",     f0,  1);
        check("fib_seed0_phase", ph0, 1);
        check("fib_seed0_cnt",   cnt0, 1);
        press(7'd1);
        check("fib_seed1_f",     f0,  1);
        check("fib_seed1_phase", ph0, 2);
        check("fib_seed1_cnt",   cnt0, 2);
        for (int i = 0; i < 5; i++) begin
            press(7'd55);   // d must be ignored in RUN
            check($sformatf("fib_term%0d", i + 2), f0, fib_exp[i]);
        end
        check("fib_cnt",       cnt0, 7);
        check("fib_ovf",       ovf0, 0);
        check("fib_sat_f",     f1,   13);
        check("cnt_saturated", cnt2, 3);
        check("fib_phase_run", ph0,  2);

        // Asynchronous reset between edges
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_f",     f0,   0);
        check("async_rst_phase", ph0,  0);
        check("async_rst_cnt",   cnt0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Add overflow: 60 + 70 = 130
        press(7'd60);
        press(7'd70);
        check("ovf_seed_f", f0, 70);
        press(7'd0);
        check("ovf_wrap_f",   f0,   2);
        check("ovf_wrap_ovf", ovf0, 1);
        check("ovf_sat_f",    f1,   127);
        check("ovf_sat_ovf",  ovf1, 1);
        press(7'd0);
        check("ovf_wrap_f2",   f0,   72);
        check("ovf_sticky2",   ovf0, 1);
        press(7'd0);
        check("ovf_wrap_f3",   f0,   74);
        check("ovf_sticky3",   ovf0, 1);
        check("ovf_sat_f3",    f1,   127);

        // Synchronous clear
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_f",     f0,   0);
        check("clr_ovf",   ovf0, 0);
        check("clr_ovf_s", ovf1, 0);
        check("clr_phase", ph0,  0);
        check("clr_cnt",   cnt0, 0);

        // Subtraction: seeds 3,10 -> 7, then 7-10 borrows
        mode = 2'b01;
        press(7'd3);
        press(7'd10);
        press(7'd0);
        check("sub_f",      f0,   7);
        check("sub_ovf",    ovf0, 0);
        check("sub_sat_f",  f1,   7);
        press(7'd0);
        check("sub_borrow_wrap_f", f0,   125);
        check("sub_borrow_ovf",    ovf0, 1);
        check("sub_borrow_sat_f",  f1,   0);
        check("sub_borrow_sat_ov", ovf1, 1);

        // clr coinciding with the step pulse in RUN
        mode = 2'b00;
        en = 1'b1;
        @(negedge clk);         // en sampled
        en = 1'b0;
        @(negedge clk);         // pulse now high, applies on next edge
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clrp_f",     f0,   0);
        check("clrp_ovf",   ovf0, 0);
        check("clrp_phase", ph0,  0);
        check("clrp_cnt",   cnt0, 0);
        repeat (3) @(negedge clk);
        check("clrp_discard_phase", ph0,  0);
        check("clrp_discard_cnt",   cnt0, 0);

        // Latency and long hold
        press(7'd4);
        check("hold_seed0_f", f0, 4);
        d  = 7'd9;
        en = 1'b1;
        @(negedge clk);
        check("lat_edge_k",  f0, 4);
        @(negedge clk);
        check("lat_edge_k1", f0, 4);
        @(negedge clk);
        check("lat_edge_k2", f0, 9);
        check("lat_phase",   ph0, 2);
        repeat (47) @(negedge clk);
        check("hold_f",   f0,   9);
        check("hold_cnt", cnt0, 2);
        en = 1'b0;
        repeat (3) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("lat2_edge_k1", f0, 9);
        @(negedge clk);
        check("lat2_edge_k2", f0, 13);
        repeat (10) @(negedge clk);
        check("hold2_f",   f0,   13);
        check("hold2_cnt", cnt0, 3);
        en = 1'b0;
        repeat (3) @(negedge clk);

        // xor then or (a=9, b=13)
        mode = 2'b10;
        press(7'd0);
        check("xor_f", f0, 4);
        mode = 2'b11;
        press(7'd0);
        check("or_f",     f0,   13);
        check("logic_ovf", ovf0, 0);
        check("logic_cnt", cnt0, 5);

        // en already high when reset is released produces one press
        rst = 1'b1;
        en  = 1'b1;
        d   = 7'd21;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_en_f",     f0,   21);
        check("rst_en_phase", ph0,  1);
        check("rst_en_cnt",   cnt0, 1);
        en = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fls_param.md
Name: fls_param

Overview:
Parametrised successor to the lab Fibonacci-like sequence block. It loads two seed terms from switches via button presses, then produces one term per press: f(n) = f(n-1) OP f(n-2), with a run-time selectable OP. It adds WIDTH/CNT_W parametrisation, an internal synchroniser with edge detection, a sticky overflow flag, optional saturation, a term counter and a synchronous clear. It sits between the board switches/button and the LED/seven-segment display logic.

Parameters:
WIDTH, 7, data width of seeds and terms
SAT, 0, 0 = wrap on overflow; 1 = clamp (add -> all-ones, sub -> zero)
CNT_W, 8, width of term counter

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
en  input  1  raw step button level (asynchronous to clk)
clr  input  1  synchronous restart to seed entry
d  input  WIDTH  seed value from switches
mode  input  2  00 add, 01 sub (f(n-1)-f(n-2)), 10 xor, 11 or
f  output  WIDTH  current term, registered
ovf  output  1  sticky overflow/borrow flag
term_cnt  output  CNT_W  terms emitted, including seeds
phase  output  2  00 SEED0, 01 SEED1, 10 RUN

Behaviour:
- Reset (rst=1, async): f=0, ovf=0, term_cnt=0, phase=SEED0, internal regs a/b=0, sync flops=0; applies immediately without a clock edge.
- Synchroniser: s1<=en, s2<=s1, s3<=s2; step pulse p = s2 & ~s3, exactly one clk wide per rising en, regardless of hold length.
- Latency: en rises before edge k -> p high in the cycle after edge k+1 -> outputs update at edge k+2.
- If en is high when rst deasserts, one pulse is generated (counts as a press).
- FSM, all transitions on p only; no idle cycle between seeding and RUN:
  - SEED0 + p: a<=d, f<=d, -> SEED1
  - SEED1 + p: b<=d, f<=d, -> RUN
  - RUN + p: r=OP(b,a) per current mode; a<=b, b<=r, f<=r; stay in RUN
  - phase encoding 11 unreachable; if reached, go to SEED0 on next clock.
- Arithmetic, (WIDTH+1)-bit internal:
  - add: carry out sets ovf.
  - sub: b-a, borrow sets ovf.
  - xor/or never set ovf.
  - SAT=0: r = low WIDTH bits.
  - SAT=1 and overflow: add -> all-ones; sub -> 0.
- ovf is sticky until rst or clr.
- mode is sampled at the pulse cycle; changing mode mid-sequence is legal and affects only later terms.
- term_cnt increments on every accepted p (seeds included) and saturates at 2^CNT_W-1.
- clr=1 at a clock edge: same effect as reset, except the sync flops are kept; clr wins over a simultaneous p, and that press is discarded.
- d is sampled only at SEED0/SEED1 pulses; it is ignored in RUN.

Test Plan:
- WIDTH=7, mode=00, seeds 1,1, then 5 presses -> f = 1,1,2,3,5,8,13; term_cnt=7; ovf=0; phase goes 00->01->10 after the 2nd press.
- WIDTH=7, SAT=0, seeds 60,70, add press -> f=2 (130 mod 128), ovf=1; two more presses (70+2=72, 2+72=74) -> ovf stays 1. With SAT=1 the same stimulus gives f=127.
- mode=01, seeds 3,10 -> 7 (ovf=0); next press 7-10 -> f=125 (SAT=0) or 0 (SAT=1), ovf=1.
- en held high for 50 cycles, then low, then high again -> exactly 2 steps; each f update lands exactly 2 edges after the en sample edge.
- rst pulsed asynchronously between edges in RUN with f=13 -> f=0, phase=00, term_cnt=0 before the next edge; seeding restarts.
- clr and p in the same cycle in RUN -> f=0, ovf=0, phase=SEED0, term_cnt=0; no term computed.
